// File: rtl/obi_arbiter_2to1.sv
// Two-requester OBI arbiter onto a single X-HEEP master port. It uses round-robin selection,
// locks the selection until the grant, and routes responses in order through a small ID FIFO.
package obi_arbiter_2to1_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module obi_arbiter_2to1
   import obi_arbiter_2to1_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  obi_req_t         req_p0,
   output obi_resp_t        resp_p0,
   input  obi_req_t         req_p1,
   output obi_resp_t        resp_p1,
   output obi_req_t         req_to_xheep,
   input  obi_resp_t        resp_from_xheep,
   output logic             busy,
   output logic             err_sticky,
   input  logic             err_clr,
   output logic [CNT_W-1:0] cnt_p0,
   output logic [CNT_W-1:0] cnt_p1
);

   localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned FCNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(MAX_OUTSTANDING);

   // ID FIFO: one bit per slot holding the port number that owns the response
   logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]          count_q, count_d;

   logic last_q, last_d;
   logic lock_q, lock_d;
   logic lock_sel_q, lock_sel_d;
   logic err_q, err_d;
   logic [CNT_W-1:0] cnt_p0_q, cnt_p0_d, cnt_p1_q, cnt_p1_d;

   logic     sel;
   obi_req_t sel_req;
   logic     empty, full;
   logic     push, pop, blocked;
   logic     mst_req, accept, head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
   endfunction

   always_comb begin
      sel = 1'b0;
      if (lock_q) begin
         sel = lock_sel_q;
      end else if (req_p0.req && req_p1.req) begin
         sel = ~last_q;
      end else if (req_p1.req) begin
         sel = 1'b1;
      end
   end

   assign sel_req = sel ? req_p1 : req_p0;
   assign empty   = (count_q == '0);
   assign full    = (count_q == FCNT_MAX);
   assign head    = fifo_q[rd_ptr_q];
   assign pop     = rst_n & resp_from_xheep.rvalid & ~empty;
   // A full FIFO may still take a new transaction when a slot frees in the same cycle
   assign blocked = full & ~pop;
   assign mst_req = rst_n & sel_req.req & ~blocked;
   assign accept  = mst_req & resp_from_xheep.gnt;
   assign push    = accept;

   always_comb begin
      req_to_xheep     = sel_req;
      req_to_xheep.req = mst_req;

      resp_p0        = '0;
      resp_p0.gnt    = accept & ~sel;
      resp_p0.rvalid = pop & ~head;
      resp_p0.rdata  = resp_from_xheep.rdata;

      resp_p1        = '0;
      resp_p1.gnt    = accept & sel;
      resp_p1.rvalid = pop & head;
      resp_p1.rdata  = resp_from_xheep.rdata;
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = sel;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + FCNT_W'(1);
         2'b01:   count_d = count_q - FCNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      last_d     = accept ? sel : last_q;
      lock_d     = mst_req & ~resp_from_xheep.gnt;
      lock_sel_d = sel;

      err_d = err_q;
      if (resp_from_xheep.rvalid && empty) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end

      cnt_p0_d = cnt_p0_q;
      cnt_p1_d = cnt_p1_q;
      if (accept && !sel && (cnt_p0_q != {CNT_W{1'b1}})) begin
         cnt_p0_d = cnt_p0_q + CNT_W'(1);
      end
      if (accept && sel && (cnt_p1_q != {CNT_W{1'b1}})) begin
         cnt_p1_d = cnt_p1_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_q     <= 1'b1;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_p0_q   <= '0;
         cnt_p1_q   <= '0;
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         err_q      <= err_d;
         cnt_p0_q   <= cnt_p0_d;
         cnt_p1_q   <= cnt_p1_d;
      end
   end

   assign busy       = rst_n & (mst_req | ~empty);
   assign err_sticky = err_q;
   assign cnt_p0     = cnt_p0_q;
   assign cnt_p1     = cnt_p1_q;

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Directed bench for obi_arbiter_2to1: expected response owners are queued at grant and
// popped when X-HEEP returns rvalid.
module tb_obi_arbiter_2to1;
   import obi_arbiter_2to1_pkg::*;

   localparam int unsigned MAX_OUT = 2;
   localparam int unsigned CNT_W   = 3;
   localparam int          CNT_SAT = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   obi_req_t         req_p0, req_p1, req_to_xheep;
   obi_resp_t        resp_p0, resp_p1, resp_from_xheep;
   logic             busy, err_sticky, err_clr;
   logic [CNT_W-1:0] cnt_p0, cnt_p1;

   int n_checks = 0;
   int n_pass   = 0;
   bit sb[$];
   int exp_cnt[2];

   always #5 clk = ~clk;

   obi_arbiter_2to1 #(
      .MAX_OUTSTANDING (MAX_OUT),
      .CNT_W           (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_p0          (req_p0),
      .resp_p0         (resp_p0),
      .req_p1          (req_p1),
      .resp_p1         (resp_p1),
      .req_to_xheep    (req_to_xheep),
      .resp_from_xheep (resp_from_xheep),
      .busy            (busy),
      .err_sticky      (err_sticky),
      .err_clr         (err_clr),
      .cnt_p0          (cnt_p0),
      .cnt_p1          (cnt_p1)
   );

   function automatic obi_req_t mk_req(input logic we, input logic [3:0] be,
                                       input logic [31:0] addr, input logic [31:0] wdata);
      obi_req_t r;
      r.req   = 1'b1;
      r.we    = we;
      r.be    = be;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      req_p0          = '0;
      req_p1          = '0;
      resp_from_xheep = '0;
      err_clr         = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
   endtask

   // Expect port p to be granted this cycle with its own request fields on the master
   task automatic chk_grant(input bit p);
      obi_req_t e;
      e = p ? req_p1 : req_p0;
      chk("mst_req", 32'(req_to_xheep.req), 32'd1);
      chk("mst_addr", req_to_xheep.addr, e.addr);
      chk("gnt_p0", 32'(resp_p0.gnt), 32'(!p));
      chk("gnt_p1", 32'(resp_p1.gnt), 32'(p));
      sb.push_back(p);
      if (exp_cnt[p] < CNT_SAT) exp_cnt[p]++;
   endtask

   // rvalid is driven this cycle: route it to the oldest queued owner, or to nobody
   task automatic chk_rsp();
      bit p;
      if (sb.size() == 0) begin
         chk("rvalid_p0_drop", 32'(resp_p0.rvalid), 32'd0);
         chk("rvalid_p1_drop", 32'(resp_p1.rvalid), 32'd0);
      end else begin
         p = sb.pop_front();
         chk("rvalid_p0", 32'(resp_p0.rvalid), 32'(!p));
         chk("rvalid_p1", 32'(resp_p1.rvalid), 32'(p));
         chk("rdata_p0", resp_p0.rdata, resp_from_xheep.rdata);
         chk("rdata_p1", resp_p1.rdata, resp_from_xheep.rdata);
      end
   endtask

   task automatic chk_cnts();
      chk("cnt_p0", 32'(cnt_p0), 32'(exp_cnt[0]));
      chk("cnt_p1", 32'(cnt_p1), 32'(exp_cnt[1]));
   endtask

   initial begin
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      // Reset with live inputs: nothing may leak to the master or the ports
      idle();
      rst_n  = 1'b0;
      req_p0 = mk_req(1'b1, 4'hf, 32'h0000_0180, 32'hdead_beef);
      resp_from_xheep.gnt = 1'b1;
      #2;
      chk("rst_mst_req", 32'(req_to_xheep.req), 32'd0);
      chk("rst_gnt_p0", 32'(resp_p0.gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_sticky), 32'd0);
      chk_cnts();
      tick();
      rst_n = 1'b1;
      idle();

      // Single p0 write, granted immediately, response next cycle
      req_p0 = mk_req(1'b1, 4'hf, 32'h0000_0180, 32'hdead_beef);
      resp_from_xheep.gnt = 1'b1;
      #2;
      chk_grant(1'b0);
      chk("busy_single", 32'(busy), 32'd1);
      chk("mst_wdata", req_to_xheep.wdata, 32'hdead_beef);
      tick();
      idle();
      resp_from_xheep.rvalid = 1'b1;
      resp_from_xheep.rdata  = 32'h1234_5678;
      #2;
      chk_cnts();
      chk_rsp();
      tick();
      idle();
      #2;
      chk("busy_idle", 32'(busy), 32'd0);

      // Contention twice back-to-back from a fresh pointer: p0, p1, p0, p1
      do_reset();
      req_p0 = mk_req(1'b0, 4'hf, 32'h0000_1000, 32'h0);
      req_p1 = mk_req(1'b0, 4'hf, 32'h0000_2000, 32'h0);
      resp_from_xheep.gnt = 1'b1;
      #2 chk_grant(1'b0);
      tick();
      resp_from_xheep.rvalid = 1'b1;
      resp_from_xheep.rdata  = 32'h0000_00a1;
      #2 chk_rsp();
      chk_grant(1'b1);
      tick();
      resp_from_xheep.rdata = 32'h0000_00a2;
      #2 chk_rsp();
      chk_grant(1'b0);
      tick();
      resp_from_xheep.rdata = 32'h0000_00a3;
      #2 chk_rsp();
      chk_grant(1'b1);
      tick();
      req_p0 = '0;
      req_p1 = '0;
      resp_from_xheep.gnt   = 1'b0;
      resp_from_xheep.rdata = 32'h0000_00a4;
      #2 chk_rsp();
      tick();
      idle();
      #2 chk_cnts();
      chk("cnt_p0_two", 32'(cnt_p0), 32'd2);
      chk("cnt_p1_two", 32'(cnt_p1), 32'd2);

      // p1 waits five cycles for gnt while p0 joins: the request must stay locked on p1
      req_p1 = mk_req(1'b1, 4'h3, 32'h0000_2040, 32'hcafe_f00d);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) req_p0 = mk_req(1'b0, 4'hf, 32'h0000_1040, 32'h0);
         #2;
         chk("lock_req", 32'(req_to_xheep.req), 32'd1);
         chk("lock_addr", req_to_xheep.addr, 32'h0000_2040);
         chk("lock_wdata", req_to_xheep.wdata, 32'hcafe_f00d);
         chk("lock_be", 32'(req_to_xheep.be), 32'h3);
         chk("lock_gnt_p0", 32'(resp_p0.gnt), 32'd0);
         tick();
      end
      resp_from_xheep.gnt = 1'b1;
      #2 chk_grant(1'b1);
      tick();
      req_p1 = '0;
      #2 chk_grant(1'b0);
      tick();
      req_p0 = '0;
      resp_from_xheep.gnt    = 1'b0;
      resp_from_xheep.rvalid = 1'b1;
      resp_from_xheep.rdata  = 32'h0000_00b1;
      #2 chk_rsp();
      tick();
      resp_from_xheep.rdata = 32'h0000_00b2;
      #2 chk_rsp();
      tick();
      idle();

      // Third request stalls on a full FIFO until the first rvalid frees a slot
      req_p0 = mk_req(1'b0, 4'hf, 32'h0000_3000, 32'h0);
      resp_from_xheep.gnt = 1'b1;
      #2 chk_grant(1'b0);
      tick();
      req_p0 = '0;
      req_p1 = mk_req(1'b0, 4'hf, 32'h0000_3004, 32'h0);
      #2 chk_grant(1'b1);
      tick();
      req_p1 = '0;
      req_p0 = mk_req(1'b0, 4'hf, 32'h0000_3008, 32'h0);
      for (int i = 0; i < 2; i++) begin
         #2;
         chk("full_mst_req", 32'(req_to_xheep.req), 32'd0);
         chk("full_gnt_p0", 32'(resp_p0.gnt), 32'd0);
         chk("full_busy", 32'(busy), 32'd1);
         tick();
      end
      resp_from_xheep.rvalid = 1'b1;
      resp_from_xheep.rdata  = 32'h0000_00c1;
      #2 chk_rsp();
      chk_grant(1'b0);
      tick();
      req_p0 = '0;
      resp_from_xheep.gnt   = 1'b0;
      resp_from_xheep.rdata = 32'h0000_00c2;
      #2 chk_rsp();
      tick();
      resp_from_xheep.rdata = 32'h0000_00c3;
      #2 chk_rsp();
      tick();
      idle();
      #2 chk_cnts();

      // Stray rvalid with nothing outstanding
      resp_from_xheep.rvalid = 1'b1;
      #2 chk_rsp();
      tick();
      idle();
      #2 chk("err_set", 32'(err_sticky), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      #2 chk("err_clr", 32'(err_sticky), 32'd0);
      err_clr = 1'b1;
      resp_from_xheep.rvalid = 1'b1;
      tick();
      idle();
      #2 chk("err_set_wins", 32'(err_sticky), 32'd1);
      err_clr = 1'b1;
      tick();
      idle();
      #2 chk("err_clr2", 32'(err_sticky), 32'd0);

      // Streaming p0 traffic drives its counter into saturation
      req_p0 = mk_req(1'b0, 4'hf, 32'h0000_4000, 32'h0);
      resp_from_xheep.gnt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) resp_from_xheep.rvalid = 1'b1;
         resp_from_xheep.rdata = 32'(i);
         #2;
         if (i > 0) chk_rsp();
         chk_grant(1'b0);
         tick();
      end
      req_p0 = '0;
      resp_from_xheep.gnt = 1'b0;
      #2 chk_rsp();
      tick();
      idle();
      #2 chk_cnts();
      chk("cnt_p0_sat", 32'(cnt_p0), 32'(CNT_SAT));

      // Reset with two outstanding; the late rvalid afterwards is an orphan
      req_p0 = mk_req(1'b0, 4'hf, 32'h0000_5000, 32'h0);
      resp_from_xheep.gnt = 1'b1;
      #2 chk_grant(1'b0);
      tick();
      #2 chk_grant(1'b0);
      tick();
      idle();
      rst_n = 1'b0;
      #2;
      chk("arst_cnt_p0", 32'(cnt_p0), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_mst_req", 32'(req_to_xheep.req), 32'd0);
      tick();
      rst_n = 1'b1;
      sb.delete();
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      resp_from_xheep.rvalid = 1'b1;
      #2 chk_rsp();
      tick();
      idle();
      #2;
      chk("late_err", 32'(err_sticky), 32'd1);
      chk("late_busy", 32'(busy), 32'd0);
      chk_cnts();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
